port_uart_tx: RTL
=================

PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter DEPTH, fixed at 4: transmit FIFO entries of 8 bits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1: one-cycle write strobe, driven when the computer writes its UART data output port.
REQ-006 SHALL have port wr_data  input  8: byte to enqueue, sampled when wr_en=1.
REQ-007 SHALL have port clr_ovr  input  1: one-cycle strobe clearing the overrun flag.
REQ-008 SHALL have port tx  output  1: serial line, registered, idle high.
REQ-009 SHALL have port status  output  8: registered status byte for a computer input port: [7] overrun, [6] busy, [5] full, [4] empty, [3] 0, [2:0] count.

Function
REQ-010 SHALL have one clock and a synchronous, active-high reset; clock port named clk, reset port named reset.
REQ-011 SHALL accept a write when wr_en=1 and (count<4 or a pop occurs in the same cycle); accepted entry visible in count after that edge.
REQ-012 SHALL drop a write when wr_en=1, count=4 and no same-cycle pop, and set overrun=1; FIFO contents unchanged.
REQ-013 SHALL keep overrun sticky until clr_ovr=1 or reset; if clr_ovr and a dropped write coincide, overrun SHALL be 1 (set wins).
REQ-014 SHALL use circular read/write pointers wrapping 3->0; order strictly first-in-first-out.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if count>0, pop head into shift register, bit index=0, baud counter=0, go START at that edge.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: tx=shift register bit index, LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 go STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE unconditionally.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit transition.
REQ-021 Latency: write at edge k into empty FIFO with FSM in IDLE -> tx=0 visible after edge k+1.
REQ-022 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames separated by exactly one IDLE cycle (tx=1).
REQ-023 busy SHALL be 1 whenever state is not IDLE.
REQ-024 full SHALL equal (count==4); empty SHALL equal (count==0); count SHALL reflect post-edge occupancy.
REQ-025 wr_data changes while wr_en=0 SHALL have no effect; a byte already in the shift register SHALL be unaffected by FIFO writes.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, tx=1, pointers=0, count=0, overrun=0, counters=0, status=8'h10.
REQ-027 Reset mid-frame SHALL abort the frame: tx=1 after that edge, all queued bytes discarded.
REQ-028 Reset SHALL take priority over wr_en, clr_ovr and FSM activity in the same cycle.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset held 2 cycles -> tx=1, status=8'h10 after release.
REQ-030 Single write 8'hA5 at edge k -> tx=0 from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop 1 for 4 cycles; status=8'h50 during frame, 8'h10 after.
REQ-031 Six writes on consecutive edges from idle -> first popped at k+1, five accepted, sixth dropped; status=8'hE4 after sixth; transmitted order equals first five bytes.
REQ-032 clr_ovr pulse after REQ-031 -> status[7]=0; clr_ovr coinciding with a dropped write -> status[7]=1.
REQ-033 Two queued bytes -> second start bit begins exactly one tx=1 cycle after first stop bit ends (41-cycle spacing between start-bit falls).
REQ-034 reset asserted during DATA bit 3 with 2 bytes queued -> tx=1 next edge, status=8'h10, no further frames without new writes.

Source files
------------

// File: rtl/port_uart_tx_if.sv
// Port-side bus of the UART transmitter: the computer's write strobe and data,
// the overrun-clear strobe, and the serial line and status byte going back.
interface port_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovr;
    logic       tx;
    logic [7:0] status;

    modport master (
        output wr_en,
        output wr_data,
        output clr_ovr,
        input  tx,
        input  status
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  clr_ovr,
        output tx,
        output status
    );
endinterface

// File: rtl/port_uart_tx.sv
// UART transmitter behind a computer output port. Written bytes go into a
// four-entry FIFO. A serialiser sends each byte as one start bit, eight data
// bits (LSB first) and one stop bit, with CLKS_PER_BIT clocks per bit. The
// status byte reports overrun, busy, full, empty and the FIFO occupancy.
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input logic           clk,
    input logic           reset,
    port_uart_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int             CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     FULL_COUNT = 3'(DEPTH);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_n;

    logic [7:0]    mem [0:3];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic [2:0]    count_n;
    logic          overrun;
    logic          overrun_n;

    logic          pop;
    logic          push;
    logic          drop;

    logic          tx_q;
    logic          tx_n;
    logic [7:0]    status_q;
    logic [7:0]    status_n;

    assign bus.tx     = tx_q;
    assign bus.status = status_q;

    // Serialiser next state. In IDLE a waiting byte is popped straight into the
    // shift register so the start bit goes out on the very next edge. The baud
    // counter restarts at zero on every state change and every data-bit change.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift_reg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    bit_n   = 3'd0;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                bit_n   = 3'd0;
            end
        endcase
    end

    // FIFO bookkeeping. A full FIFO still accepts a write when the serialiser
    // pops in the same cycle. A dropped write sets overrun, and that wins over a
    // simultaneous clear.
    always_comb begin
        push      = bus.wr_en && ((count < FULL_COUNT) || pop);
        drop      = bus.wr_en && !push;
        count_n   = count + {2'b00, push} - {2'b00, pop};
        overrun_n = overrun;
        if (drop) begin
            overrun_n = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_n = 1'b0;
        end
    end

    // The line level and status byte come from post-edge values, so both
    // outputs are registered yet reflect the state entered at that same edge.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[bit_n];
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
        status_n = {overrun_n, (state_n != IDLE), (count_n == FULL_COUNT),
                    (count_n == 3'd0), 1'b0, count_n};
    end

    // Serialiser state register and registered outputs. Reset aborts any frame
    // and returns the line to idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            tx_q      <= 1'b1;
            status_q  <= 8'h10;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_idx   <= bit_n;
            shift_reg <= shift_n;
            tx_q      <= tx_n;
            status_q  <= status_n;
        end
    end

    // FIFO pointers, occupancy and sticky overrun. Reset discards queued bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count   <= count_n;
            overrun <= overrun_n;
        end
    end

    // FIFO storage. The head is read combinationally during the pop, so a
    // same-cycle write into the slot being freed cannot corrupt the popped byte.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

endmodule
